// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
//   WIDTH_DEF   : default operand/result width
//   SEG_W_DEF   : default bits added per pipeline stage
//   op_e        : operation select (add / subtract)
//   calc_stages : number of pipeline stages, ceil(width / seg_w)
package pipelined_add_sub_pkg;

    localparam int unsigned WIDTH_DEF = 24;
    localparam int unsigned SEG_W_DEF = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned seg_w);
        return (width + seg_w - 1) / seg_w;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_seg_adder.sv
// Combinational W-bit segment adder used by every pipeline stage.
//   a, b : segment operands
//   cin  : carry into the segment LSB
//   sum  : segment sum
//   cout : carry out of the segment MSB
module seg_adder #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign {cout, sum} = total;

endmodule

// File: rtl/pipelined_add_sub.sv
// Segmented, carry-pipelined adder/subtractor with valid/ready handshake.
// Each stage adds one SEG_W-bit slice and registers the slice sum and carry;
// upper operand slices and lower partial sums ride along with their beat.
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  : operand handshake
//   a, b, cin, sub     : operands, carry-in (add only), 0=add / 1=subtract
//   out_valid/out_ready: result handshake
//   sum, cout          : result and carry out (subtract: 1 = no borrow)
//   ovf                : signed overflow, present only with
//                        `define PIPELINED_ADD_SUB_OVF_EN
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SEG_W = SEG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = calc_stages(WIDTH, SEG_W);

    op_e             op;
    logic [WIDTH-1:0] b_cond;
    logic             cin_eff;

    // Subtract is a + ~b + 1, so the caller's carry-in is ignored.
    assign op      = op_e'(sub);
    assign b_cond  = (op == OP_SUB) ? ~b : b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

    // Per-stage register outputs, each element driven by its own stage.
    logic             stg_valid [STAGES];
    logic             stg_carry [STAGES];
    logic [WIDTH-1:0] stg_a     [STAGES];
    logic [WIDTH-1:0] stg_bc    [STAGES];
    logic [WIDTH-1:0] stg_sum   [STAGES];

    // The whole pipeline moves together; only a held output blocks it.
    assign in_ready = !rst && !(stg_valid[STAGES-1] && !out_ready);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SEG_W;
        localparam int unsigned SW = (k == int'(STAGES) - 1) ? (WIDTH - LO) : SEG_W;

        logic             v_src;
        logic             c_src;
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] bc_src;
        logic [WIDTH-1:0] sum_src;

        logic [SW-1:0]    seg_sum;
        logic             carry_d;
        logic [WIDTH-1:0] sum_d;

        logic             valid_q;
        logic             carry_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] bc_q;
        logic [WIDTH-1:0] sum_q;

        if (k == 0) begin : g_head
            assign v_src   = in_valid;
            assign c_src   = cin_eff;
            assign a_src   = a;
            assign bc_src  = b_cond;
            assign sum_src = '0;
        end else begin : g_body
            assign v_src   = stg_valid[k-1];
            assign c_src   = stg_carry[k-1];
            assign a_src   = stg_a[k-1];
            assign bc_src  = stg_bc[k-1];
            assign sum_src = stg_sum[k-1];
        end

        seg_adder #(
            .W (SW)
        ) u_seg (
            .a    (a_src[LO +: SW]),
            .b    (bc_src[LO +: SW]),
            .cin  (c_src),
            .sum  (seg_sum),
            .cout (carry_d)
        );

        // Lower slices come from earlier stages; this stage fills its own slice.
        always_comb begin
            sum_d            = sum_src;
            sum_d[LO +: SW]  = seg_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                a_q     <= '0;
                bc_q    <= '0;
                sum_q   <= '0;
            end else if (in_ready) begin
                valid_q <= v_src;
                carry_q <= carry_d;
                a_q     <= a_src;
                bc_q    <= bc_src;
                sum_q   <= sum_d;
            end
        end

        assign stg_valid[k] = valid_q;
        assign stg_carry[k] = carry_q;
        assign stg_a[k]     = a_q;
        assign stg_bc[k]    = bc_q;
        assign stg_sum[k]   = sum_q;
    end

    assign out_valid = stg_valid[STAGES-1];
    assign sum       = stg_sum[STAGES-1];
    assign cout      = stg_carry[STAGES-1];

`ifdef PIPELINED_ADD_SUB_OVF_EN
    // Operands of equal sign producing a result of the other sign.
    // Uses the conditioned b, so it covers subtract as well.
    assign ovf = (stg_a[STAGES-1][WIDTH-1] == stg_bc[STAGES-1][WIDTH-1]) &&
                 (stg_sum[STAGES-1][WIDTH-1] != stg_a[STAGES-1][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;

    localparam int unsigned W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPELINED_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Directed vectors: a, b, cin, sub -> hand-computed sum, cout
    logic [W-1:0] va   [5] = '{24'h123456, 24'h000010, 24'h800000, 24'h0000FF, 24'h000000};
    logic [W-1:0] vb   [5] = '{24'h111111, 24'h000001, 24'h800000, 24'h000001, 24'h000001};
    logic         vcin [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         vsub [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] vsum [5] = '{24'h234567, 24'h00000F, 24'h000001, 24'h000101, 24'hFFFFFF};
    logic         vco  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    pipelined_add_sub #(
        .WIDTH (24),
        .SEG_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADD_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 24'h000000) begin n_bad++; $display("FAIL reset_sum: got %h want 000000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
`ifdef PIPELINED_ADD_SUB_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_carry();
        int lat;
        a = 24'hFFFFFF; b = 24'h000001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL add_latency: got %0d want 3", lat); end
        n_cmp++; if (sum !== 24'h000000) begin n_bad++; $display("FAIL add_sum: got %h want 000000", sum); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL add_cout: got %b want 1", cout); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_sub_borrow();
        int lat;
        a = 24'h000005; b = 24'h000007; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL sub_latency: got %0d want 3", lat); end
        n_cmp++; if (sum !== 24'hFFFFFE) begin n_bad++; $display("FAIL sub_sum: got %h want fffffe", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL sub_cout: got %b want 0", cout); end
        tick();
        sub = 1'b0; cin = 1'b0;
    endtask

    task automatic test_stall();
        logic [W-1:0] exp_s [4];
        int sent, got, stalls, cyc;
        logic acc;
        exp_s = '{24'd2, 24'd4, 24'd6, 24'd8};
        sent = 0; got = 0; stalls = 0; cyc = 0;
        sub = 1'b0; cin = 1'b0;
        while (got < 4 && cyc < 40) begin
            out_ready = (out_valid === 1'b1 && stalls < 2) ? 1'b0 : 1'b1;
            if (sent < 4) begin
                in_valid = 1'b1; a = W'(sent + 1); b = W'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_ready == 1'b0) begin
                stalls++;
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                n_cmp++; if (sum !== 24'd2) begin n_bad++; $display("FAIL stall_hold_sum: got %h want 000002", sum); end
            end
            if (out_valid === 1'b1 && out_ready == 1'b1) begin
                n_cmp++; if (sum !== exp_s[got]) begin n_bad++; $display("FAIL stall_result%0d: got %h want %h", got, sum, exp_s[got]); end
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got != 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", got); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'(i + 10); b = 24'h000001;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_accept%0d: got %b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_flushed%0d: got %b want 0", i, out_valid); end
            tick();
        end
        a = 24'h000100; b = 24'h000023; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; cin = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL mid_latency: got %0d want 3", lat); end
        n_cmp++; if (sum !== 24'h000124) begin n_bad++; $display("FAIL mid_first_sum: got %h want 000124", sum); end
        tick();
    endtask

    task automatic test_back_to_back();
        int sent, got, cyc, first_c, last_c;
        logic acc;
        sent = 0; got = 0; cyc = 0; first_c = -1; last_c = -1;
        out_ready = 1'b1;
        while (got < 5 && cyc < 40) begin
            if (sent < 5) begin
                in_valid = 1'b1; a = va[sent]; b = vb[sent]; cin = vcin[sent]; sub = vsub[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                n_cmp++; if (sum !== vsum[got]) begin n_bad++; $display("FAIL b2b_sum%0d: got %h want %h", got, sum, vsum[got]); end
                n_cmp++; if (cout !== vco[got]) begin n_bad++; $display("FAIL b2b_cout%0d: got %b want %b", got, cout, vco[got]); end
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (got != 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", got); end
        n_cmp++; if (last_c - first_c != 4) begin n_bad++; $display("FAIL b2b_throughput: span %0d want 4", last_c - first_c); end
    endtask

    task automatic test_flow_pattern();
        logic [15:0] iv_pat, or_pat;
        int sent, got, cyc;
        logic acc;
        iv_pat = 16'b1011_0110_1101_0011;
        or_pat = 16'b1100_1011_0101_1001;
        sent = 0; got = 0; cyc = 0;
        while (got < 5 && cyc < 80) begin
            out_ready = or_pat[cyc % 16];
            if (sent < 5 && iv_pat[cyc % 16]) begin
                in_valid = 1'b1; a = va[sent]; b = vb[sent]; cin = vcin[sent]; sub = vsub[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++; if (in_ready !== !(out_valid && !out_ready)) begin n_bad++; $display("FAIL flow_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready)); end
            if (out_valid === 1'b1 && out_ready == 1'b1) begin
                n_cmp++; if (sum !== vsum[got]) begin n_bad++; $display("FAIL flow_sum%0d: got %h want %h", got, sum, vsum[got]); end
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got != 5) begin n_bad++; $display("FAIL flow_count: got %0d want 5", got); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flow_no_dup: got %b want 0", out_valid); end
    endtask

`ifdef PIPELINED_ADD_SUB_OVF_EN
    task automatic test_ovf();
        int lat;
        out_ready = 1'b1;
        a = 24'h7FFFFF; b = 24'h000001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_cmp++; if (sum !== 24'h800000) begin n_bad++; $display("FAIL ovf_add_sum: got %h want 800000", sum); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_add_flag: got %b want 1", ovf); end
        tick();
        a = 24'h800000; b = 24'h800000; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_cmp++; if (sum !== 24'h000000) begin n_bad++; $display("FAIL ovf_sub_sum: got %h want 000000", sum); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_cout: got %b want 1", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_sub_flag: got %b want 0", ovf); end
        tick();
        sub = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_stall();
        test_reset_midflight();
        test_back_to_back();
        test_flow_pattern();
`ifdef PIPELINED_ADD_SUB_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
